// File: rtl/pwm_fader.sv
// rtl/pwm_fader.sv - level sequencer stepping the pwm level toward a target, one-shot or breathing
module pwm_fader #(
    parameter int WIDTH  = 8,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe,
    input  logic              load,
    input  logic [WIDTH-1:0]  target,
    input  logic [RATE_W-1:0] rate,
    input  logic              breathe,
    output logic [WIDTH-1:0]  level,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    level_q, level_d;
    logic [WIDTH-1:0]    target_q, target_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [RATE_W-1:0]   pc_q, pc_d;
    logic                breathe_q, breathe_d;
    logic                done_q, done_d;

    logic [WIDTH-1:0]    level_inc, level_dec, floor_lvl;

    assign level_inc = level_q + WIDTH'(1);
    assign level_dec = level_q - WIDTH'(1);
    // Breathing always bottoms out at zero; a one-shot fade stops at its target.
    assign floor_lvl = breathe_q ? '0 : target_q;

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        target_d  = target_q;
        rate_d    = rate_q;
        pc_d      = pc_q;
        breathe_d = breathe_q;
        done_d    = 1'b0;

        if (load) begin
            target_d  = target;
            rate_d    = rate;
            breathe_d = breathe;
            pc_d      = '0;
            if (target == level_q && !breathe) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (target == '0 && breathe) begin
                if (level_q != '0) begin
                    state_d = DOWN;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else if (target > level_q) begin
                state_d = UP;
            end else begin
                state_d = DOWN;
            end
        end else if (strobe && state_q != IDLE) begin
            if (pc_q != rate_q) begin
                pc_d = pc_q + RATE_W'(1);
            end else begin
                pc_d = '0;
                if (state_q == UP) begin
                    level_d = level_inc;
                    if (level_inc == target_q) begin
                        if (breathe_q) begin
                            state_d = DOWN;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    level_d = level_dec;
                    if (level_dec == floor_lvl) begin
                        if (!breathe_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (target_q != '0) begin
                            state_d = UP;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            level_q   <= '0;
            target_q  <= '0;
            rate_q    <= '0;
            pc_q      <= '0;
            breathe_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            target_q  <= target_d;
            rate_q    <= rate_d;
            pc_q      <= pc_d;
            breathe_q <= breathe_d;
            done_q    <= done_d;
        end
    end

    assign level = level_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_pwm_fader.sv
// tb/tb_pwm_fader.sv - vector-table bench for pwm_fader with an expected-output scoreboard
module tb_pwm_fader;

    logic       clk = 1'b0;
    logic       reset, strobe, load, breathe;
    logic [7:0] target, rate;
    logic [7:0] level;
    logic       busy, done;

    pwm_fader #(.WIDTH(8), .RATE_W(8)) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .load(load),
        .target(target), .rate(rate), .breathe(breathe),
        .level(level), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, s, l;
        logic [7:0] t, r;
        logic       b;
        logic [7:0] el;
        logic       eb, ed;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] el;
        logic       eb, ed;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic s, input logic l, input logic [7:0] t,
                       input logic [7:0] r, input logic b, input logic [7:0] el,
                       input logic eb, input logic ed);
        vec_t v;
        v.rst = rst; v.s = s; v.l = l; v.t = t; v.r = r; v.b = b;
        v.el = el; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic idle(input int n, input logic [7:0] el, input logic eb);
        for (int i = 0; i < n; i++) add(0, 0, 0, 8'd0, 8'd0, 0, el, eb, 0);
    endtask

    task automatic strb(input logic [7:0] el, input logic eb, input logic ed);
        add(0, 1, 0, 8'd0, 8'd0, 0, el, eb, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] tri_seq [10];
        tri_seq = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd3, 8'd2};

        // Reset state
        add(1, 0, 0, 8'd0, 8'd0, 0, 8'd0, 0, 0);
        add(1, 1, 0, 8'd0, 8'd0, 0, 8'd0, 0, 0);
        // Up-fade to 4 at rate 1, strobe every third cycle
        add(0, 1, 1, 8'd4, 8'd1, 0, 8'd0, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            idle(2, 8'((k - 1) / 2), 1);
            strb(8'(k / 2), k < 8, k == 8);
        end
        idle(1, 8'd4, 0);
        strb(8'd4, 0, 0);
        // Down-fade 4 -> 1 at rate 0
        add(0, 0, 1, 8'd1, 8'd0, 0, 8'd4, 1, 0);
        strb(8'd3, 1, 0);
        strb(8'd2, 1, 0);
        strb(8'd1, 0, 1);
        strb(8'd1, 0, 0);
        strb(8'd1, 0, 0);
        // Climb to 5, then no-op load of the same target
        add(0, 0, 1, 8'd5, 8'd0, 0, 8'd1, 1, 0);
        strb(8'd2, 1, 0);
        strb(8'd3, 1, 0);
        strb(8'd4, 1, 0);
        strb(8'd5, 0, 1);
        add(0, 0, 1, 8'd5, 8'd0, 0, 8'd5, 0, 1);
        idle(1, 8'd5, 0);
        // Breathe 0..3 then a one-shot fade to 0 mid-sequence
        add(1, 0, 0, 8'd0, 8'd0, 0, 8'd0, 0, 0);
        add(0, 0, 1, 8'd3, 8'd0, 1, 8'd0, 1, 0);
        for (int i = 0; i < 10; i++) strb(tri_seq[i], 1, 0);
        add(0, 0, 1, 8'd0, 8'd0, 0, 8'd2, 1, 0);
        strb(8'd1, 1, 0);
        strb(8'd0, 0, 1);
        idle(1, 8'd0, 0);
        // Retarget to 0 colliding with a qualifying strobe at level 2
        add(0, 0, 1, 8'd6, 8'd2, 0, 8'd0, 1, 0);
        for (int k = 1; k <= 8; k++) strb(8'(k / 3), 1, 0);
        add(0, 1, 1, 8'd0, 8'd2, 0, 8'd2, 1, 0);
        for (int k = 1; k <= 6; k++) strb(8'(2 - k / 3), k < 6, k == 6);
        // Reset mid-fade
        add(0, 0, 1, 8'd6, 8'd0, 0, 8'd0, 1, 0);
        strb(8'd1, 1, 0);
        strb(8'd2, 1, 0);
        strb(8'd3, 1, 0);
        add(1, 0, 0, 8'd0, 8'd0, 0, 8'd0, 0, 0);
        for (int k = 0; k < 3; k++) strb(8'd0, 0, 0);
        // Breathe toward 0 from level 0 completes at once
        add(0, 0, 1, 8'd0, 8'd0, 1, 8'd0, 0, 1);
        idle(1, 8'd0, 0);
        // Slowest rate: one step per 256 strobes
        add(0, 0, 1, 8'd1, 8'd255, 0, 8'd0, 1, 0);
        for (int k = 1; k <= 256; k++) strb(8'(k / 256), k < 256, k == 256);
        strb(8'd1, 0, 0);
        // Breathe toward 0 from a non-zero level: ramps down with no done
        add(0, 0, 1, 8'd0, 8'd0, 1, 8'd1, 1, 0);
        strb(8'd0, 0, 0);
        strb(8'd0, 0, 0);

        reset = 1'b1; strobe = 1'b0; load = 1'b0;
        target = '0; rate = '0; breathe = 1'b0;

        foreach (vecs[i]) begin
            exp_t e;
            @(negedge clk);
            reset = vecs[i].rst; strobe = vecs[i].s; load = vecs[i].l;
            target = vecs[i].t; rate = vecs[i].r; breathe = vecs[i].b;
            e.idx = i; e.el = vecs[i].el; e.eb = vecs[i].eb; e.ed = vecs[i].ed;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty vec%0d: no expected entry", i);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (level !== e.el) begin
                    errors++;
                    $display("FAIL level vec%0d: got %0d required %0d", e.idx, level, e.el);
                end
                checks++;
                if (busy !== e.eb) begin
                    errors++;
                    $display("FAIL busy vec%0d: got %0b required %0b", e.idx, busy, e.eb);
                end
                checks++;
                if (done !== e.ed) begin
                    errors++;
                    $display("FAIL done vec%0d: got %0b required %0b", e.idx, done, e.ed);
                end
            end
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
